// File: rtl/fifo_write_arbiter_if.sv
// Purpose: producer/fifo-side bundle for fifo_write_arbiter.
//   master : environment side (producers drive valid/data, fifo drives full)
//   slave  : arbiter side (drives ready, fifo write strobe/data, grant status)
// Signals:
//   req_valid         NUM_REQ             per-requester data valid
//   req_data          NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         NUM_REQ             per-requester accept, at most one bit high
//   fifo_full         1                   fifo full_flag
//   fifo_write_enable 1                   fifo write strobe
//   fifo_write_data   DATA_WIDTH          fifo write data
//   grant_id          $clog2(NUM_REQ)     current owner index
//   grant_active      1                   high while a grant is held
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_write_enable;
   logic [DATA_WIDTH-1:0]         fifo_write_data;
   logic [ID_W-1:0]               grant_id;
   logic                          grant_active;

   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_write_enable, fifo_write_data, grant_id, grant_active
   );

   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_write_enable, fifo_write_data, grant_id, grant_active
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Purpose: shares the single write port of the dual-clock fifo between NUM_REQ
//   producers in the write (clk) domain. Round-robin grant with bursts bounded
//   by MAX_BURST; fifo full is backpressure to the granted producer only.
// Ports:
//   clk          write-domain clock
//   write_reset  asynchronous, active-high reset
//   bus          fifo_write_arbiter_if.slave (requester handshake, fifo write
//                port, grant_id / grant_active status)
//   stall_count  [15:0] saturating stall counter, present only when
//                ARB_STALL_CNT_EN is defined
// Optional feature macro: ARB_STALL_CNT_EN
//
// state | meaning
// IDLE  | arbitration cycle: pick next owner searching from last_owner+1
// GRANT | owner may transfer up to MAX_BURST beats; full stalls, drop releases
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                clk,
   input  logic                write_reset,
   fifo_write_arbiter_if.slave bus
`ifdef ARB_STALL_CNT_EN
   ,
   output logic [15:0]         stall_count
`endif
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int BC_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [ID_W-1:0] last_owner_q, last_owner_d;
   logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;

   logic [ID_W-1:0] winner;
   logic            winner_found;
   logic            grant_active;
   logic            owner_valid;
   logic            transfer;

   assign grant_active = (state_q == GRANT);
   assign owner_valid  = bus.req_valid[grant_id_q];
   assign transfer     = grant_active & owner_valid & ~bus.fifo_full;

   // Rotating search: the previous owner is visited last, so it has the
   // lowest priority at the next arbitration.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!winner_found && bus.req_valid[(int'(last_owner_q) + k) % NUM_REQ]) begin
            winner       = ID_W'((int'(last_owner_q) + k) % NUM_REQ);
            winner_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge write_reset) begin
      if (write_reset) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_owner_q <= ID_W'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (winner_found) begin
               state_d     = GRANT;
               grant_id_d  = winner;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (!owner_valid) begin
               state_d      = IDLE;
               last_owner_d = grant_id_q;
            end else if (transfer) begin
               if (burst_cnt_q == BC_W'(MAX_BURST - 1)) begin
                  state_d      = IDLE;
                  last_owner_d = grant_id_q;
               end else begin
                  burst_cnt_d = burst_cnt_q + BC_W'(1);
               end
            end
            // valid but fifo full: hold grant and burst count
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (grant_active) begin
         bus.req_ready[grant_id_q] = owner_valid & ~bus.fifo_full;
      end
   end

   // Data is gated in IDLE so every output reads zero out of reset.
   assign bus.fifo_write_enable = transfer;
   assign bus.fifo_write_data   = grant_active ? bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH]
                                               : '0;
   assign bus.grant_id          = grant_id_q;
   assign bus.grant_active      = grant_active;

`ifdef ARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge write_reset) begin
      if (write_reset) begin
         stall_cnt_q <= '0;
      end else if (grant_active && owner_valid && bus.fifo_full && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
   logic clk;
   logic write_reset;

   fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

`ifdef ARB_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk         (clk),
      .write_reset (write_reset),
      .bus         (bus.slave)
`ifdef ARB_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         id;
      logic [7:0] data;
   } wr_t;

   wr_t q[$];
   wr_t e;
   int  n_tests = 0;
   int  n_fail  = 0;
   int  n_wr    = 0;
   int  cyc     = 0;
   int  base;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic exp_wr(input int c, input int id);
      wr_t w;
      w.cyc  = c;
      w.id   = id;
      w.data = 8'hA0 + 8'(id);
      q.push_back(w);
   endtask

   // Monitor: checks every write the fifo sees against the scoreboard.
   always @(negedge clk) begin
      if (!write_reset) begin
         n_tests++;
         if (!$onehot0(bus.req_ready)) begin
            n_fail++;
            $display("FAIL ready_onehot: cycle %0d req_ready=%b, required one-hot or zero", cyc, bus.req_ready);
         end
         if (bus.fifo_write_enable) begin
            n_wr++;
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: cycle %0d id %0d data %h, required no write",
                        cyc, bus.grant_id, bus.fifo_write_data);
            end else begin
               e = q.pop_front();
               if (cyc != e.cyc || int'(bus.grant_id) != e.id || bus.fifo_write_data != e.data ||
                   bus.req_ready != (4'b0001 << e.id)) begin
                  n_fail++;
                  $display("FAIL write: got cycle %0d id %0d data %h ready %b, required cycle %0d id %0d data %h ready %b",
                           cyc, bus.grant_id, bus.fifo_write_data, bus.req_ready,
                           e.cyc, e.id, e.data, 4'b0001 << e.id);
               end
            end
         end
      end
   end

   initial begin
      write_reset   = 1'b1;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'hA0 + 8'(i);
      #2;
      chk("reset_we",     int'(bus.fifo_write_enable), 0);
      chk("reset_ready",  int'(bus.req_ready), 0);
      chk("reset_active", int'(bus.grant_active), 0);
      chk("reset_gid",    int'(bus.grant_id), 0);
      chk("reset_data",   int'(bus.fifo_write_data), 0);
      tick();
      write_reset = 1'b0;

      // Round robin: all requesters, grants 0,1,2,3,0, 20 writes in 25 cycles
      base = cyc;
      bus.req_valid = 4'hF;
      for (int g = 0; g < 5; g++)
         for (int b = 0; b < 4; b++) exp_wr(base + 5*g + 1 + b, g % 4);
      repeat (25) tick();
      bus.req_valid = '0;
      chk("rr_writes_25cyc", n_wr, 20);
      tick();

      // Backpressure: req 2 alone, full during cycles 3..7
      base = cyc;
      bus.req_valid = 4'b0100;
      exp_wr(base + 1, 2);
      exp_wr(base + 2, 2);
      exp_wr(base + 8, 2);
      exp_wr(base + 9, 2);
      repeat (3) tick();
      bus.fifo_full = 1'b1;
      repeat (2) tick();
      #1;
      chk("stall_active", int'(bus.grant_active), 1);
      chk("stall_gid",    int'(bus.grant_id), 2);
      chk("stall_ready",  int'(bus.req_ready), 0);
      chk("stall_we",     int'(bus.fifo_write_enable), 0);
      repeat (3) tick();
      bus.fifo_full = 1'b0;
      repeat (2) tick();
      bus.req_valid = '0;
      #1;
      chk("bp_idle_after_burst", int'(bus.grant_active), 0);
      chk("bp_writes", n_wr, 24);
      tick();

      // Early release: req 1 two beats, then req 2 wins before req 1
      base = cyc;
      bus.req_valid = 4'b0110;
      exp_wr(base + 1, 1);
      exp_wr(base + 2, 1);
      for (int b = 0; b < 4; b++) exp_wr(base + 5 + b, 2);
      for (int b = 0; b < 4; b++) exp_wr(base + 10 + b, 1);
      repeat (3) tick();
      bus.req_valid = 4'b0100;
      tick();
      #1;
      chk("release_idle", int'(bus.grant_active), 0);
      bus.req_valid = 4'b0110;
      repeat (5) tick();
      bus.req_valid = 4'b0010;
      repeat (5) tick();
      bus.req_valid = '0;
      tick();

      // Single requester re-wins after one idle cycle
      base = cyc;
      bus.req_valid = 4'b1000;
      for (int b = 0; b < 4; b++) exp_wr(base + 1 + b, 3);
      for (int b = 0; b < 4; b++) exp_wr(base + 6 + b, 3);
      repeat (10) tick();
      bus.req_valid = '0;
      tick();

      // Asynchronous reset mid-burst
      base = cyc;
      bus.req_valid = 4'b0001;
      exp_wr(base + 1, 0);
      repeat (2) tick();
      #3;
      write_reset = 1'b1;
      #1;
      chk("mid_rst_we",     int'(bus.fifo_write_enable), 0);
      chk("mid_rst_ready",  int'(bus.req_ready), 0);
      chk("mid_rst_active", int'(bus.grant_active), 0);
      chk("mid_rst_gid",    int'(bus.grant_id), 0);
      chk("mid_rst_data",   int'(bus.fifo_write_data), 0);
      repeat (2) tick();
      write_reset = 1'b0;
      base = cyc;
      for (int b = 0; b < 4; b++) exp_wr(base + 1 + b, 0);
      repeat (5) tick();
      bus.req_valid = '0;
      tick();

`ifdef ARB_STALL_CNT_EN
      chk("stall_cnt_clear", int'(stall_count), 0);
      bus.req_valid = 4'b0001;
      bus.fifo_full = 1'b1;
      repeat (11) tick();
      chk("stall_cnt_10", int'(stall_count), 10);
      repeat (70000) tick();
      chk("stall_cnt_sat", int'(stall_count), 16'hFFFF);
      bus.req_valid = '0;
      tick();
      bus.fifo_full = 1'b0;
      tick();
`endif

      repeat (2) tick();
      chk("missing_writes", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
